// File: rtl/sync_pkg.sv
// Shared definitions for the worker-side step barrier: state encoding and
// default widths used by sync_worker_agent and barrier_wait_timer.
package sync_pkg;

   // Default width of step counters and num_steps.
   localparam int SYNC_DATA_WIDTH     = 32;
   // Default barrier-wait budget before the stall flag raises.
   localparam int SYNC_TIMEOUT_CYCLES = 1024;
   // Width of the barrier wait counter (independent of DATA_WIDTH).
   localparam int SYNC_WAIT_CNT_W     = 32;

   // Agent state encoding, kept as plain constants for legacy tools.
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LAUNCH  = 3'd1;
   localparam logic [2:0] ST_BUSY    = 3'd2;
   localparam logic [2:0] ST_BARRIER = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/barrier_wait_timer.sv
// Saturating barrier wait counter with a sticky timeout flag. The counter
// advances while enabled and clears on release; the flag sets when the count
// reaches TIMEOUT_CYCLES and holds until explicitly cleared.
module barrier_wait_timer
   import sync_pkg::*;
#(
   parameter int CNT_W          = SYNC_WAIT_CNT_W,
   parameter int TIMEOUT_CYCLES = SYNC_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_clr_cnt,
   input  logic i_clr_flag,
   output logic o_timeout
);

   localparam bit               TO_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_timeout;

   // Next count holds at all-ones so a very long stall cannot wrap to zero.
   always_comb begin
      w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
   end

   // Wait counter: clear has priority over counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr_cnt) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_cnt_nxt;
      end
   end

   // Sticky flag: sets on the edge where the count reaches the budget.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timeout <= 1'b0;
      end else if (i_clr_flag) begin
         r_timeout <= 1'b0;
      end else if (TO_EN && i_en && (w_cnt_nxt == TO_VAL)) begin
         r_timeout <= 1'b1;
      end
   end

   assign o_timeout = r_timeout;

endmodule

// File: rtl/sync_worker_agent.sv
// Worker-side end of the dual-worker step barrier. Launches one step on the
// local engine, waits for its done pulse, raises finished, and advances only
// once the sync controller reports the partner has finished too (rdy while
// finished). Stops after the latched number of steps.
module sync_worker_agent
   import sync_pkg::*;
#(
   parameter int DATA_WIDTH     = SYNC_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = SYNC_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] num_steps,
   input  logic                  rdy,
   output logic                  finished,
   output logic                  eng_start,
   output logic [DATA_WIDTH-1:0] eng_step,
   input  logic                  eng_done,
   output logic                  busy,
   output logic                  all_done,
   output logic [DATA_WIDTH-1:0] step_count,
   output logic                  barrier_timeout
);

   logic [2:0]            r_state;
   logic [DATA_WIDTH-1:0] r_num;
   logic [DATA_WIDTH-1:0] r_count;
   logic [DATA_WIDTH-1:0] r_step;

   logic                  w_idle_like;
   logic                  w_accept;
   logic                  w_in_barrier;
   logic                  w_release;
   logic [DATA_WIDTH-1:0] w_count_inc;

   // Decode of the events that move the sequencer.
   always_comb begin
      w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE);
      w_accept     = w_idle_like && start;
      w_in_barrier = (r_state == ST_BARRIER);
      w_release    = w_in_barrier && rdy;
      w_count_inc  = r_count + 1'b1;
   end

   // Step sequencer: IDLE/DONE -> LAUNCH -> BUSY -> BARRIER -> LAUNCH/DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_num   <= '0;
         r_count <= '0;
         r_step  <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_num   <= num_steps;
                  r_count <= '0;
                  r_step  <= '0;
                  r_state <= (num_steps == '0) ? ST_DONE : ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               r_state <= ST_BUSY;
            end
            ST_BUSY: begin
               if (eng_done) begin
                  r_state <= ST_BARRIER;
               end
            end
            ST_BARRIER: begin
               if (rdy) begin
                  r_count <= w_count_inc;
                  r_step  <= r_step + 1'b1;
                  r_state <= (w_count_inc == r_num) ? ST_DONE : ST_LAUNCH;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Barrier stall watchdog; the count restarts for every step.
   barrier_wait_timer #(
      .CNT_W          (SYNC_WAIT_CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_in_barrier),
      .i_clr_cnt  (w_release | w_accept),
      .i_clr_flag (w_accept),
      .o_timeout  (barrier_timeout)
   );

   // Outputs decode straight from registered state, so they are glitch-free
   // and finished drops in the cycle after release or reset.
   assign finished   = (r_state == ST_BARRIER);
   assign eng_start  = (r_state == ST_LAUNCH);
   assign busy       = (r_state == ST_LAUNCH) || (r_state == ST_BUSY) ||
                       (r_state == ST_BARRIER);
   assign all_done   = (r_state == ST_DONE);
   assign eng_step   = r_step;
   assign step_count = r_count;

endmodule

// File: tb/tb_sync_worker_agent.sv
// Bench for sync_worker_agent: two agents, behavioural engines, a selectable
// rdy source (self, dual-controller AND, starved, or bench-driven), and a
// scoreboard of expected launch/release/done/timeout events with cycle stamps.
module tb_sync_worker_agent;

   localparam int DW = 32;
   localparam int TO = 16;

   typedef struct {
      int val;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          start_a, start_b;
   logic [DW-1:0] num_a, num_b;
   logic          rdy_a, rdy_b;
   logic          fin_a, fin_b, es_a, es_b, busy_a, busy_b, ad_a, ad_b, to_a, to_b;
   logic [DW-1:0] step_a, step_b, cnt_a, cnt_b;
   logic          eng_a, eng_b, spur_a, done_a, done_b;

   int   mode;     // 0 self, 1 dual controller, 2 starved, 3 bench-driven
   logic tb_rdy;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   ev_t qla[$], qra[$], qda[$], qta[$], qlb[$], qrb[$], qdb[$];

   assign rdy_a  = (mode == 0) ? fin_a :
                   (mode == 1) ? (fin_a & fin_b) :
                   (mode == 3) ? tb_rdy : 1'b0;
   assign rdy_b  = (mode == 1) ? (fin_a & fin_b) : 1'b0;
   assign done_a = eng_a | spur_a;
   assign done_b = eng_b;

   sync_worker_agent #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .num_steps(num_a), .rdy(rdy_a),
      .finished(fin_a), .eng_start(es_a), .eng_step(step_a), .eng_done(done_a),
      .busy(busy_a), .all_done(ad_a), .step_count(cnt_a), .barrier_timeout(to_a));

   sync_worker_agent #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .num_steps(num_b), .rdy(rdy_b),
      .finished(fin_b), .eng_start(es_b), .eng_step(step_b), .eng_done(done_b),
      .busy(busy_b), .all_done(ad_b), .step_count(cnt_b), .barrier_timeout(to_b));

   always @(posedge clk) cyc <= cyc + 1;

   // Engine models: done pulses exactly D cycles after the eng_start cycle.
   int d_a = 4, d_b = 9, at_a = -1, at_b = -1;
   always @(negedge clk) begin
      if (es_a) at_a = cyc + d_a;
      if (es_b) at_b = cyc + d_b;
      eng_a = (cyc == at_a);
      eng_b = (cyc == at_b);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic unexp(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=unexpected_event expected=none at_cycle=%0d", nm, cyc);
   endtask

   // Monitor: pops the expected event for every observed DUT event.
   logic pf_a = 1'b0, pd_a = 1'b0, pt_a = 1'b0, pf_b = 1'b0, pd_b = 1'b0;
   always @(negedge clk) begin
      ev_t e;
      if (rst !== 1'b1 && es_a === 1'b1) begin
         if (qla.size() == 0) unexp("launch_a");
         else begin e = qla.pop_front(); chk("launch_a_step", step_a, e.val); chk("launch_a_cyc", cyc, e.cyc); end
      end
      if (rst !== 1'b1 && es_b === 1'b1) begin
         if (qlb.size() == 0) unexp("launch_b");
         else begin e = qlb.pop_front(); chk("launch_b_step", step_b, e.val); chk("launch_b_cyc", cyc, e.cyc); end
      end
      if (pf_a && fin_a === 1'b0) begin
         if (qra.size() == 0) unexp("release_a");
         else begin e = qra.pop_front(); chk("release_a_count", cnt_a, e.val); chk("release_a_cyc", cyc, e.cyc); end
      end
      if (pf_b && fin_b === 1'b0) begin
         if (qrb.size() == 0) unexp("release_b");
         else begin e = qrb.pop_front(); chk("release_b_count", cnt_b, e.val); chk("release_b_cyc", cyc, e.cyc); end
      end
      if (!pd_a && ad_a === 1'b1) begin
         if (qda.size() == 0) unexp("done_a");
         else begin e = qda.pop_front(); chk("done_a_count", cnt_a, e.val); chk("done_a_cyc", cyc, e.cyc); end
      end
      if (!pd_b && ad_b === 1'b1) begin
         if (qdb.size() == 0) unexp("done_b");
         else begin e = qdb.pop_front(); chk("done_b_count", cnt_b, e.val); chk("done_b_cyc", cyc, e.cyc); end
      end
      if (!pt_a && to_a === 1'b1) begin
         if (qta.size() == 0) unexp("timeout_a");
         else begin e = qta.pop_front(); chk("timeout_a_cyc", cyc, e.cyc); end
      end
      if (to_b === 1'b1) unexp("timeout_b");
      pf_a = (fin_a === 1'b1);
      pf_b = (fin_b === 1'b1);
      pd_a = (ad_a === 1'b1);
      pd_b = (ad_b === 1'b1);
      pt_a = (to_a === 1'b1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
   endtask

   function automatic ev_t ev(input int v, input int c);
      ev_t e;
      e.val = v;
      e.cyc = c;
      return e;
   endfunction

   initial begin
      int t0, tr, n;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; num_a = '0; num_b = '0;
      mode = 0; tb_rdy = 1'b0; spur_a = 1'b0;

      // Reset held three cycles, then idle with no start.
      tick(3);
      chk("rst_finished", fin_a, 0);
      chk("rst_eng_start", es_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_all_done", ad_a, 0);
      chk("rst_timeout", to_a, 0);
      chk("rst_eng_step", step_a, 0);
      chk("rst_step_count", cnt_a, 0);
      chk("rst_b_busy", busy_b, 0);
      rst = 1'b0;
      tick(5);
      chk("idle_busy", busy_a, 0);
      chk("idle_all_done", ad_a, 0);

      // Single agent, rdy tied to finished, D=4, three steps.
      mode = 0; d_a = 4; t0 = cyc; num_a = 3; start_a = 1'b1;
      qla.push_back(ev(0, t0 + 1)); qla.push_back(ev(1, t0 + 7)); qla.push_back(ev(2, t0 + 13));
      qra.push_back(ev(1, t0 + 7)); qra.push_back(ev(2, t0 + 13)); qra.push_back(ev(3, t0 + 19));
      qda.push_back(ev(3, t0 + 19));
      tick(1); start_a = 1'b0;
      tick(25);
      chk("single_step_count", cnt_a, 3);
      chk("single_all_done", ad_a, 1);
      chk("single_busy", busy_a, 0);

      // Dual agents through the controller: A D=2, B D=9, two steps.
      do_reset();
      mode = 1; d_a = 2; d_b = 9; t0 = cyc; num_a = 2; num_b = 2;
      start_a = 1'b1; start_b = 1'b1;
      qla.push_back(ev(0, t0 + 1)); qla.push_back(ev(1, t0 + 12));
      qlb.push_back(ev(0, t0 + 1)); qlb.push_back(ev(1, t0 + 12));
      qra.push_back(ev(1, t0 + 12)); qra.push_back(ev(2, t0 + 23));
      qrb.push_back(ev(1, t0 + 12)); qrb.push_back(ev(2, t0 + 23));
      qda.push_back(ev(2, t0 + 23)); qdb.push_back(ev(2, t0 + 23));
      tick(1); start_a = 1'b0; start_b = 1'b0;
      n = 0;
      for (int i = 0; i < 11; i++) begin
         if (fin_a === 1'b1) n++;
         tick(1);
      end
      chk("dual_a_hold_cycles", n, 8);
      tick(15);
      chk("dual_a_count", cnt_a, 2);
      chk("dual_b_count", cnt_b, 2);
      chk("dual_a_done", ad_a, 1);
      chk("dual_b_done", ad_b, 1);

      // num_steps = 0: straight to DONE, no launch, finished never high.
      do_reset();
      mode = 0; t0 = cyc; num_a = 0; start_a = 1'b1;
      qda.push_back(ev(0, t0 + 1));
      tick(1); start_a = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (fin_a === 1'b1 || es_a === 1'b1) n++;
         tick(1);
      end
      chk("zero_no_activity", n, 0);

      // Timeout: partner never finishes; flag rises 16 cycles into BARRIER.
      do_reset();
      mode = 2; d_a = 2; t0 = cyc; num_a = 1; start_a = 1'b1;
      qla.push_back(ev(0, t0 + 1));
      qta.push_back(ev(1, t0 + 20));
      tick(1); start_a = 1'b0;
      tick(29);
      chk("timeout_set", to_a, 1);
      chk("timeout_still_waiting", fin_a, 1);
      tr = cyc;
      qra.push_back(ev(1, tr + 1)); qda.push_back(ev(1, tr + 1));
      mode = 3; tb_rdy = 1'b1;
      tick(1); tb_rdy = 1'b0;
      chk("timeout_sticky", to_a, 1);
      num_a = 0; start_a = 1'b1;
      tick(1); start_a = 1'b0;
      chk("timeout_cleared_by_start", to_a, 0);
      chk("timeout_restart_done", ad_a, 1);

      // start during BUSY is ignored.
      do_reset();
      mode = 0; d_a = 4; t0 = cyc; num_a = 2; start_a = 1'b1;
      qla.push_back(ev(0, t0 + 1)); qla.push_back(ev(1, t0 + 7));
      qra.push_back(ev(1, t0 + 7)); qra.push_back(ev(2, t0 + 13));
      qda.push_back(ev(2, t0 + 13));
      tick(1); start_a = 1'b0;
      tick(2); num_a = 7; start_a = 1'b1;
      tick(1); start_a = 1'b0;
      tick(15);
      chk("busy_start_count", cnt_a, 2);

      // rdy in BUSY and spurious eng_done in BARRIER are ignored.
      do_reset();
      mode = 3; tb_rdy = 1'b0; d_a = 2; t0 = cyc; num_a = 1; start_a = 1'b1;
      qla.push_back(ev(0, t0 + 1));
      qra.push_back(ev(1, t0 + 9)); qda.push_back(ev(1, t0 + 9));
      tick(1); start_a = 1'b0;
      tick(1); tb_rdy = 1'b1;
      tick(2); tb_rdy = 1'b0;
      chk("rdy_in_busy_no_release", fin_a, 1);
      tick(1); spur_a = 1'b1;
      tick(2); spur_a = 1'b0;
      chk("spurious_done_hold", fin_a, 1);
      chk("spurious_done_count", cnt_a, 0);
      tick(1); tb_rdy = 1'b1;
      tick(1); tb_rdy = 1'b0;
      tick(3);
      chk("ignored_final_done", ad_a, 1);

      // Reset while BUSY aborts on the next edge.
      do_reset();
      mode = 0; d_a = 9; t0 = cyc; num_a = 5; start_a = 1'b1;
      qla.push_back(ev(0, t0 + 1));
      tick(1); start_a = 1'b0;
      tick(2);
      chk("abort_busy_before", busy_a, 1);
      rst = 1'b1;
      tick(1);
      chk("abort_finished", fin_a, 0);
      chk("abort_busy", busy_a, 0);
      chk("abort_eng_start", es_a, 0);
      chk("abort_step", step_a, 0);
      rst = 1'b0;
      tick(12);
      chk("abort_stays_idle", busy_a, 0);

      chk("left_launch_a", qla.size(), 0);
      chk("left_launch_b", qlb.size(), 0);
      chk("left_release_a", qra.size(), 0);
      chk("left_release_b", qrb.size(), 0);
      chk("left_done_a", qda.size(), 0);
      chk("left_done_b", qdb.size(), 0);
      chk("left_timeout_a", qta.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=no_finish expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
